// File: rtl/sync_edge_filter.sv
// sync_edge_filter
//
// Sits right after a slow-to-fast single-bit synchronizer, in the
// synchronizer's receive clock domain. It deglitches the synchronized level
// and turns filtered level changes into single-cycle rise/fall pulses.
// Selected edges set a sticky event flag, which is cleared by an acknowledge.
// A second sticky flag records edges that arrive while an event is still
// pending. Selected edges are also counted by a saturating counter.
//
// Parameters
//   FILTER_CYCLES : consecutive samples of a new level needed to accept it (>=1)
//   CNT_WIDTH     : event counter width (>=1)
//   EDGE_SEL      : 0 = rising, 1 = falling, 2 or 3 = both edges qualify
//
// Ports
//   in_clk_receive : receive-domain clock, rising edge
//   in_rst         : synchronous active-high reset
//   in_data_sync   : synchronized input level
//   in_ack         : clears out_event and out_overrun
//   in_cnt_clr     : clears out_event_cnt
//   out_level      : filtered level
//   out_rise       : one-cycle pulse on a filtered 0->1 change
//   out_fall       : one-cycle pulse on a filtered 1->0 change
//   out_event      : sticky flag, set by a qualified edge
//   out_overrun    : sticky flag, qualified edge while out_event was pending
//   out_event_cnt  : saturating count of qualified edges
module sync_edge_filter #(
  parameter int FILTER_CYCLES = 4,
  parameter int CNT_WIDTH     = 8,
  parameter int EDGE_SEL      = 0
) (
  input  logic                 in_clk_receive,
  input  logic                 in_rst,
  input  logic                 in_data_sync,
  input  logic                 in_ack,
  input  logic                 in_cnt_clr,
  output logic                 out_level,
  output logic                 out_rise,
  output logic                 out_fall,
  output logic                 out_event,
  output logic                 out_overrun,
  output logic [CNT_WIDTH-1:0] out_event_cnt
);

  localparam int FCW = $clog2(FILTER_CYCLES + 1);
  localparam logic [FCW-1:0]       FC_LAST = FCW'(FILTER_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [FCW-1:0]       fcnt_reg;
  logic                 level_reg;
  logic                 rise_reg;
  logic                 fall_reg;
  logic                 event_reg;
  logic                 overrun_reg;
  logic [CNT_WIDTH-1:0] cnt_reg;
  logic                 qual;

  // Stability filter. fcnt_reg counts consecutive samples that differ from
  // the current filtered level; any agreeing sample restarts the count.
  // The pulses are registered together with the level so all three change
  // on the same edge.
  always_ff @(posedge in_clk_receive) begin
    if (in_rst) begin
      fcnt_reg  <= '0;
      level_reg <= 1'b0;
      rise_reg  <= 1'b0;
      fall_reg  <= 1'b0;
    end else begin
      rise_reg <= 1'b0;
      fall_reg <= 1'b0;
      if (in_data_sync == level_reg) begin
        fcnt_reg <= '0;
      end else if (fcnt_reg == FC_LAST) begin
        // This sample completes the run: accept the new level now.
        level_reg <= in_data_sync;
        fcnt_reg  <= '0;
        rise_reg  <= in_data_sync;
        fall_reg  <= ~in_data_sync;
      end else begin
        fcnt_reg <= fcnt_reg + FCW'(1);
      end
    end
  end

  // Qualified edge, derived from the registered pulses, so flag and
  // counter react one edge after the pulse.
  always_comb begin
    qual = rise_reg | fall_reg;
    if (EDGE_SEL == 0) begin
      qual = rise_reg;
    end else if (EDGE_SEL == 1) begin
      qual = fall_reg;
    end
  end

  // Sticky flags. A new qualified edge always wins over an acknowledge.
  // Overrun is only raised when the pending event was not being acknowledged
  // on the same edge.
  always_ff @(posedge in_clk_receive) begin
    if (in_rst) begin
      event_reg   <= 1'b0;
      overrun_reg <= 1'b0;
    end else if (qual) begin
      event_reg <= 1'b1;
      if (event_reg && !in_ack) begin
        overrun_reg <= 1'b1;
      end
    end else if (in_ack) begin
      event_reg   <= 1'b0;
      overrun_reg <= 1'b0;
    end
  end

  // Saturating event counter. A clear coinciding with an edge leaves a count
  // of one, so that edge is not lost.
  always_ff @(posedge in_clk_receive) begin
    if (in_rst) begin
      cnt_reg <= '0;
    end else if (qual) begin
      if (in_cnt_clr) begin
        cnt_reg <= CNT_WIDTH'(1);
      end else if (cnt_reg != CNT_MAX) begin
        cnt_reg <= cnt_reg + CNT_WIDTH'(1);
      end
    end else if (in_cnt_clr) begin
      cnt_reg <= '0;
    end
  end

  assign out_level     = level_reg;
  assign out_rise      = rise_reg;
  assign out_fall      = fall_reg;
  assign out_event     = event_reg;
  assign out_overrun   = overrun_reg;
  assign out_event_cnt = cnt_reg;

endmodule
